// File: rtl/cache_arb_pkg.sv
// Shared encodings and default widths for the cache miss arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStore = 3'd1,
    StFillI = 3'd2,
    StFillD = 3'd3,
    StDrain = 3'd4
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/arb_store_counter.sv
// Store occupancy down-counter: load at grant, flags first and last store cycles.
module arb_store_counter #(
  parameter int unsigned WRITE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_first,
  output logic o_done
);

  localparam int unsigned CntW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(WRITE_CYCLES - 1);

  logic [CntW-1:0] w_cnt_q;
  logic [CntW-1:0] w_cnt_d;
  logic            w_en;

  always_comb begin
    w_cnt_d = w_cnt_q;
    if (i_load) begin
      w_cnt_d = LoadVal;
    end else if (w_cnt_q != '0) begin
      w_cnt_d = w_cnt_q - 1'b1;
    end
  end

  assign w_en = i_load | i_dec;

  dff #(
    .Width(CntW)
  ) u_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en (w_en),
    .i_d  (w_cnt_d),
    .o_q  (w_cnt_q)
  );

  assign o_first = (w_cnt_q == LoadVal);
  assign o_done  = (w_cnt_q == '0);

endmodule

// File: rtl/dff.sv
// Plain enabled flop with synchronous active-high clear.
module dff #(
  parameter int unsigned Width = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cache_miss_arbiter.sv
// Arbitrates I/D cache misses and write-through stores onto one fill FSM and one memory port.
module cache_miss_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned WRITE_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_icache_miss,
  input  logic [ADDR_W-1:0] i_icache_miss_addr,
  input  logic              i_dcache_miss,
  input  logic [ADDR_W-1:0] i_dcache_miss_addr,
  input  logic              i_st_req,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  output logic              o_st_ack,
  output logic              o_fill_miss_detected,
  output logic [ADDR_W-1:0] o_fill_miss_address,
  input  logic [ADDR_W-1:0] i_fill_mem_address,
  input  logic              i_fill_write_tag,
  output logic              o_mem_enable,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_in,
  output logic              o_icache_fill_sel,
  output logic              o_dcache_fill_sel,
  output logic              o_icache_stall,
  output logic              o_dcache_stall
);

  arb_state_e        r_state;
  arb_state_e        w_state_d;
  logic              r_last_grant;
  logic              r_first;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_latch_en;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_data_d;
  logic              w_fill_grant;
  logic              w_fill_done;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_first;
  logic              w_cnt_done;
  logic              w_in_fill;
  logic              w_store_wr;

  arb_store_counter #(
    .WRITE_CYCLES(WRITE_CYCLES)
  ) u_store_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst_n),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_first(w_cnt_first),
    .o_done (w_cnt_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= GRANT_D;
      r_first      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_state <= w_state_d;
      r_first <= w_fill_grant;
      if (w_latch_en) begin
        r_addr <= w_addr_d;
        r_data <= w_data_d;
      end
      if (w_fill_done) begin
        r_last_grant <= (r_state == StFillD) ? GRANT_D : GRANT_I;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_latch_en   = 1'b0;
    w_addr_d     = r_addr;
    w_data_d     = r_data;
    w_fill_grant = 1'b0;
    w_fill_done  = 1'b0;
    w_cnt_load   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_st_req) begin
          w_state_d  = StStore;
          w_latch_en = 1'b1;
          w_addr_d   = i_st_addr;
          w_data_d   = i_st_data;
          w_cnt_load = 1'b1;
        // On a tie the D side wins only if I was served last.
        end else if (i_dcache_miss && (!i_icache_miss || r_last_grant == GRANT_I)) begin
          w_state_d    = StFillD;
          w_latch_en   = 1'b1;
          w_addr_d     = i_dcache_miss_addr;
          w_fill_grant = 1'b1;
        end else if (i_icache_miss) begin
          w_state_d    = StFillI;
          w_latch_en   = 1'b1;
          w_addr_d     = i_icache_miss_addr;
          w_fill_grant = 1'b1;
        end
      end
      StStore: begin
        if (w_cnt_done) w_state_d = StIdle;
      end
      StFillI, StFillD: begin
        if (i_fill_write_tag) begin
          w_state_d   = StDrain;
          w_fill_done = 1'b1;
        end
      end
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_cnt_dec  = (r_state == StStore);
  assign w_in_fill  = (r_state == StFillI) || (r_state == StFillD);
  assign w_store_wr = (r_state == StStore) && w_cnt_first;

  always_comb begin
    o_st_ack             = (r_state == StStore) && w_cnt_done;
    o_fill_miss_detected = w_in_fill && r_first;
    o_fill_miss_address  = w_in_fill ? r_addr : '0;
    o_mem_enable         = w_store_wr || w_in_fill;
    o_mem_wr             = w_store_wr;
    o_mem_addr           = '0;
    o_mem_data_in        = '0;
    if (w_store_wr) begin
      o_mem_addr    = r_addr;
      o_mem_data_in = r_data;
    end else if (w_in_fill) begin
      o_mem_addr = i_fill_mem_address;
    end
    o_icache_fill_sel = (r_state == StFillI);
    o_dcache_fill_sel = (r_state == StFillD);
    o_icache_stall    = i_icache_miss || (r_state == StFillI);
    o_dcache_stall    = i_dcache_miss || (i_st_req && !o_st_ack) ||
                        (r_state == StFillD) || (r_state == StStore);
  end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed vector bench for cache_miss_arbiter (WRITE_CYCLES = 4).
module tb_cache_miss_arbiter;

  typedef struct packed {
    logic        ack;
    logic        fmd;
    logic [15:0] fma;
    logic        en;
    logic        wr;
    logic [15:0] ma;
    logic [15:0] md;
    logic        isel;
    logic        dsel;
    logic        ist;
    logic        dst;
  } out_t;

  typedef struct {
    logic        rst;
    logic        im;
    logic [15:0] ia;
    logic        dm;
    logic [15:0] da;
    logic        sr;
    logic [15:0] sa;
    logic [15:0] sd;
    logic [15:0] fmain;
    logic        wt;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im = 1'b0, dm = 1'b0, sr = 1'b0, wt = 1'b0;
  logic [15:0] ia = '0, da = '0, sa = '0, sd = '0, fmain = '0;

  logic        o_st_ack, o_fill_miss_detected, o_mem_enable, o_mem_wr;
  logic [15:0] o_fill_miss_address, o_mem_addr, o_mem_data_in;
  logic        o_icache_fill_sel, o_dcache_fill_sel, o_icache_stall, o_dcache_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_miss_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .WRITE_CYCLES(4)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst),
    .i_icache_miss       (im),
    .i_icache_miss_addr  (ia),
    .i_dcache_miss       (dm),
    .i_dcache_miss_addr  (da),
    .i_st_req            (sr),
    .i_st_addr           (sa),
    .i_st_data           (sd),
    .o_st_ack            (o_st_ack),
    .o_fill_miss_detected(o_fill_miss_detected),
    .o_fill_miss_address (o_fill_miss_address),
    .i_fill_mem_address  (fmain),
    .i_fill_write_tag    (wt),
    .o_mem_enable        (o_mem_enable),
    .o_mem_wr            (o_mem_wr),
    .o_mem_addr          (o_mem_addr),
    .o_mem_data_in       (o_mem_data_in),
    .o_icache_fill_sel   (o_icache_fill_sel),
    .o_dcache_fill_sel   (o_dcache_fill_sel),
    .o_icache_stall      (o_icache_stall),
    .o_dcache_stall      (o_dcache_stall)
  );

  function automatic out_t eo(input logic ack, input logic fmd, input logic [15:0] fma,
                              input logic en, input logic wr, input logic [15:0] ma,
                              input logic [15:0] md, input logic isel, input logic dsel,
                              input logic ist, input logic dst);
    eo = {ack, fmd, fma, en, wr, ma, md, isel, dsel, ist, dst};
  endfunction

  function automatic vec_t mk(input logic r, input logic i_m, input logic [15:0] i_a,
                              input logic d_m, input logic [15:0] d_a, input logic s_r,
                              input logic [15:0] s_a, input logic [15:0] s_d,
                              input logic [15:0] f_a, input logic w_t, input out_t e);
    mk.rst = r;   mk.im = i_m; mk.ia = i_a; mk.dm = d_m; mk.da = d_a; mk.sr = s_r;
    mk.sa = s_a;  mk.sd = s_d; mk.fmain = f_a; mk.wt = w_t; mk.exp = e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  vec_t q[$];
  out_t got;
  out_t z;
  int   lat;
  int   writes;

  initial begin
    z = eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);

    // Reset state
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));
    // Lone I miss at 0x1234
    q.push_back(mk(0, 1, 16'h1234, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0,
                   eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0)));
    q.push_back(mk(0, 1, 16'h1234, 0, 16'h0, 0, 16'h0, 16'h0, 16'h1234, 0,
                   eo(0, 1, 16'h1234, 1, 0, 16'h1234, 16'h0, 1, 0, 1, 0)));
    q.push_back(mk(0, 1, 16'h1234, 0, 16'h0, 0, 16'h0, 16'h0, 16'h1236, 0,
                   eo(0, 0, 16'h1234, 1, 0, 16'h1236, 16'h0, 1, 0, 1, 0)));
    q.push_back(mk(0, 1, 16'h1234, 0, 16'h0, 0, 16'h0, 16'h0, 16'h1238, 1,
                   eo(0, 0, 16'h1234, 1, 0, 16'h1238, 16'h0, 1, 0, 1, 0)));
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));
    // Store with both misses pending: store, then D fill, then I fill
    q.push_back(mk(0, 1, 16'h2000, 1, 16'h0040, 1, 16'h0100, 16'hBEEF, 16'h0, 0,
                   eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 1)));
    q.push_back(mk(0, 1, 16'h2000, 1, 16'h0040, 1, 16'h0100, 16'hBEEF, 16'h0, 1,
                   eo(0, 0, 16'h0, 1, 1, 16'h0100, 16'hBEEF, 0, 0, 1, 1)));
    for (int k = 0; k < 2; k++) begin
      q.push_back(mk(0, 1, 16'h2000, 1, 16'h0040, 1, 16'h0100, 16'hBEEF, 16'h0, 0,
                     eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 1)));
    end
    q.push_back(mk(0, 1, 16'h2000, 1, 16'h0040, 1, 16'h0100, 16'hBEEF, 16'h0, 0,
                   eo(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 1)));
    q.push_back(mk(0, 1, 16'h2000, 1, 16'h0040, 0, 16'h0, 16'h0, 16'h0, 0,
                   eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 1)));
    q.push_back(mk(0, 1, 16'h2000, 1, 16'h0080, 0, 16'h0, 16'h0, 16'h0040, 0,
                   eo(0, 1, 16'h0040, 1, 0, 16'h0040, 16'h0, 0, 1, 1, 1)));
    q.push_back(mk(0, 1, 16'h2000, 1, 16'h0080, 0, 16'h0, 16'h0, 16'h0042, 1,
                   eo(0, 0, 16'h0040, 1, 0, 16'h0042, 16'h0, 0, 1, 1, 1)));
    q.push_back(mk(0, 1, 16'h2000, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0,
                   eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0)));
    q.push_back(mk(0, 1, 16'h2000, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0,
                   eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0)));
    q.push_back(mk(0, 1, 16'h2000, 0, 16'h0, 0, 16'h0, 16'h0, 16'h2000, 1,
                   eo(0, 1, 16'h2000, 1, 0, 16'h2000, 16'h0, 1, 0, 1, 0)));
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));
    // Both misses held across four fills: D, I, D, I
    for (int k = 0; k < 4; k++) begin
      logic        sd_d;
      logic [15:0] fa;
      sd_d = (k % 2 == 0);
      fa   = sd_d ? 16'h4000 : 16'h3000;
      q.push_back(mk(0, 1, 16'h3000, 1, 16'h4000, 0, 16'h0, 16'h0, 16'h0, 0,
                     eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 1)));
      q.push_back(mk(0, 1, 16'h3000, 1, 16'h4000, 0, 16'h0, 16'h0, fa, 1,
                     eo(0, 1, fa, 1, 0, fa, 16'h0, ~sd_d, sd_d, 1, 1)));
      q.push_back(mk(0, 1, 16'h3000, 1, 16'h4000, 0, 16'h0, 16'h0, 16'h0, 0,
                     eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 1)));
    end
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));
    // Reset during FILL_D; held D miss is re-granted
    q.push_back(mk(0, 0, 16'h0, 1, 16'h0040, 0, 16'h0, 16'h0, 16'h0, 0,
                   eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1)));
    q.push_back(mk(0, 0, 16'h0, 1, 16'h0040, 0, 16'h0, 16'h0, 16'h0040, 0,
                   eo(0, 1, 16'h0040, 1, 0, 16'h0040, 16'h0, 0, 1, 0, 1)));
    q.push_back(mk(1, 0, 16'h0, 1, 16'h0040, 0, 16'h0, 16'h0, 16'h0042, 0,
                   eo(0, 0, 16'h0040, 1, 0, 16'h0042, 16'h0, 0, 1, 0, 1)));
    q.push_back(mk(0, 0, 16'h0, 1, 16'h0040, 0, 16'h0, 16'h0, 16'h0, 0,
                   eo(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 1)));
    q.push_back(mk(0, 0, 16'h0, 1, 16'h0040, 0, 16'h0, 16'h0, 16'h0040, 1,
                   eo(0, 1, 16'h0040, 1, 0, 16'h0040, 16'h0, 0, 1, 0, 1)));
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));
    // Spurious write_tag in IDLE
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 1, z));
    q.push_back(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, z));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < q.size(); i++) begin
      rst = q[i].rst; im = q[i].im; ia = q[i].ia; dm = q[i].dm; da = q[i].da;
      sr = q[i].sr; sa = q[i].sa; sd = q[i].sd; fmain = q[i].fmain; wt = q[i].wt;
      #1;
      got = {o_st_ack, o_fill_miss_detected, o_fill_miss_address, o_mem_enable, o_mem_wr,
             o_mem_addr, o_mem_data_in, o_icache_fill_sel, o_dcache_fill_sel,
             o_icache_stall, o_dcache_stall};
      check($sformatf("vec%0d", i), 64'(got), 64'(q[i].exp));
      tick();
    end

    // Store latency with write_tag held high throughout
    rst = 1'b0; im = 1'b0; dm = 1'b0; fmain = '0;
    sr = 1'b1; sa = 16'h0200; sd = 16'h1357; wt = 1'b1;
    lat = 0;
    writes = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (o_mem_wr) begin
        writes++;
        check("store_wdata", 64'({o_mem_addr, o_mem_data_in}), 64'({16'h0200, 16'h1357}));
      end
      if (o_st_ack) begin
        lat = c;
        break;
      end
      tick();
    end
    check("store_latency", 64'(lat), 64'd5);
    check("store_writes", 64'(writes), 64'd1);
    tick();
    sr = 1'b0; wt = 1'b0;
    #1;
    check("store_idle", 64'({o_st_ack, o_mem_enable, o_dcache_stall}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
